// File: rtl/shftreg_piso_seq.sv
// Sequencer feeding a parallel-load/serial-shift register: accepts a word, loads it,
// then paces LENGTH-1 active-low shift strobes at a programmable bit period.
module shftreg_piso_seq #(
    parameter int LENGTH = 6,
    parameter int DIV_W  = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_data,
    input  logic [DIV_W-1:0]  div,
    input  logic              fill_bit,
    output logic [LENGTH-1:0] sr_p_in,
    output logic              sr_load_n,
    output logic              sr_shift_n,
    output logic              sr_s_in,
    output logic              busy,
    output logic              word_done
);

    localparam int BC_W = $clog2(LENGTH);
    localparam int GC_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(LENGTH - 1);
    localparam logic [GC_W-1:0] GAP_INIT = GC_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [LENGTH-1:0] p_in_q, p_in_d;
    logic              s_in_q, s_in_d;
    logic              load_n_q, load_n_d;
    logic              shift_n_q, shift_n_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        div_d     = div_q;
        p_in_d    = p_in_q;
        s_in_d    = s_in_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    p_in_d  = in_data;
                    s_in_d  = fill_bit;
                    div_d   = div;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bit_cnt_d = '0;
                div_cnt_d = div_q;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt_q == '0) begin
                    div_cnt_d = div_q;
                    if (bit_cnt_q == LAST_BIT) begin
                        gap_cnt_d = GAP_INIT;
                        state_d   = (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered, so decode them from the state the next cycle will be in.
        load_n_d  = (state_d != S_LOAD);
        shift_n_d = !((state_d == S_SHIFT) && (div_cnt_d == '0) && (bit_cnt_d != LAST_BIT));
        done_d    = (state_d == S_SHIFT) && (div_cnt_d == '0) && (bit_cnt_d == LAST_BIT);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            div_q     <= '0;
            p_in_q    <= '0;
            s_in_q    <= 1'b0;
            load_n_q  <= 1'b1;
            shift_n_q <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            div_q     <= div_d;
            p_in_q    <= p_in_d;
            s_in_q    <= s_in_d;
            load_n_q  <= load_n_d;
            shift_n_q <= shift_n_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign sr_p_in    = p_in_q;
    assign sr_s_in    = s_in_q;
    assign sr_load_n  = load_n_q;
    assign sr_shift_n = shift_n_q;
    assign word_done  = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shftreg_piso_seq.sv
// Bench for shftreg_piso_seq: table vectors, hand-written corner sequences and random words,
// checked cycle by cycle against an arithmetic timing model and a model downstream register.
module tb_shftreg_piso_seq;

    localparam int L  = 6;
    localparam int DW = 8;
    localparam int G  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [L-1:0]  in_data = '0;
    logic [DW-1:0] div = '0;
    logic          fill_bit = 1'b0;
    logic [L-1:0]  sr_p_in;
    logic          sr_load_n, sr_shift_n, sr_s_in, busy, word_done;

    shftreg_piso_seq #(.LENGTH(L), .DIV_W(DW), .GAP(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .div        (div),
        .fill_bit   (fill_bit),
        .sr_p_in    (sr_p_in),
        .sr_load_n  (sr_load_n),
        .sr_shift_n (sr_shift_n),
        .sr_s_in    (sr_s_in),
        .busy       (busy),
        .word_done  (word_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int overlap_cnt = 0;
    logic [L-1:0] model_sr = '0;

    // Downstream register model plus event counters
    always @(posedge clk) begin
        if (!sr_load_n && !sr_shift_n) overlap_cnt <= overlap_cnt + 1;
        if (!sr_load_n)       model_sr <= sr_p_in;
        else if (!sr_shift_n) model_sr <= {model_sr[L-2:0], sr_s_in};
        if (word_done) done_cnt <= done_cnt + 1;
        if (in_valid && in_ready && !rst) acc_cnt <= acc_cnt + 1;
    end

    typedef struct packed {
        logic load_n;
        logic shift_n;
        logic done;
        logic busy;
        logic ready;
    } ctl_t;

    typedef struct {
        logic [L-1:0]  data;
        logic [DW-1:0] d;
        logic          fill;
        int            exp_done_k;
        int            exp_shifts;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected control outputs at cycle k after accept, from the bit-period rules
    function automatic ctl_t model_ctl(input int k, input int d);
        ctl_t c;
        int   p;
        int   t;
        int   b;
        bit   last;
        p = d + 1;
        t = L * p;
        c.load_n  = (k != 1);
        c.shift_n = 1'b1;
        c.done    = 1'b0;
        if (k >= 2 && k <= 1 + t) begin
            b    = (k - 2) / p;
            last = (((k - 2) % p) == p - 1);
            c.shift_n = !(last && b < L - 1);
            c.done    = last && (b == L - 1);
        end
        c.busy  = (k >= 1) && (k <= 1 + t + G);
        c.ready = !c.busy;
        return c;
    endfunction

    function automatic logic model_ser(input logic [L-1:0] data, input int k, input int d);
        int idx;
        idx = L - 1 - (k - 2) / (d + 1);
        return data[idx];
    endfunction

    task automatic offer(input logic [L-1:0] data, input logic [DW-1:0] d, input logic fill);
        int i;
        i = 0;
        while (!in_ready && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = data;
            div      = d;
            fill_bit = fill;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = ~data;
            fill_bit = ~fill;
            div      = d ^ 8'h5A;
        end
    endtask

    // Walks cycles 1..stop_k (or the whole word through in_ready) after an accept
    task automatic check_word(input logic [L-1:0] data, input int d, input logic fill,
                              input int stop_k, input bit chg, input logic [DW-1:0] new_div,
                              input int exp_done_k, input int exp_shifts);
        int   last_k;
        int   kmax;
        int   done_k;
        int   shifts;
        ctl_t e;
        ctl_t a;
        logic [L-1:0] ef;
        last_k = 2 + L * (d + 1) + G;
        kmax   = (stop_k > 0) ? stop_k : last_k;
        done_k = -1;
        shifts = 0;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (chg && k == 3) div = new_div;
            e = model_ctl(k, d);
            a = '{sr_load_n, sr_shift_n, word_done, busy, in_ready};
            chk($sformatf("ctl k=%0d", k), 32'(a), 32'(e));
            if (!sr_shift_n) shifts++;
            if (word_done) done_k = k;
            if (k == 1) begin
                chk("p_in_latched", 32'(sr_p_in), 32'(data));
                chk("s_in_latched", 32'(sr_s_in), 32'(fill));
            end
            if (k >= 2 && k <= 1 + L * (d + 1))
                chk($sformatf("serial k=%0d", k), 32'(model_sr[L-1]), 32'(model_ser(data, k, d)));
        end
        if (stop_k == 0) begin
            ef = L'(data << (L - 1));
            if (fill) ef = ef | L'((1 << (L - 1)) - 1);
            chk("done_cycle", 32'(done_k), 32'(exp_done_k));
            chk("shift_count", 32'(shifts), 32'(exp_shifts));
            chk("final_sr", 32'(model_sr), 32'(ef));
        end
        $display("word data=%b div=%0d fill=%0d done_k=%0d shifts=%0d", data, d, fill, done_k, shifts);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 32'({sr_p_in, sr_load_n, sr_shift_n, sr_s_in, busy, word_done, in_ready}),
            32'({{L{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   d0;
        int   a0;
        logic [L-1:0]  rd;
        logic [DW-1:0] rdiv;
        logic          rf;
        bit            rchg;

        vecs[0] = '{6'b101101, 8'd0,   1'b0, 7,    5};
        vecs[1] = '{6'b101101, 8'd3,   1'b1, 25,   5};
        vecs[2] = '{6'b110010, 8'd1,   1'b0, 13,   5};
        vecs[3] = '{6'b000001, 8'd2,   1'b1, 19,   5};
        vecs[4] = '{6'b011100, 8'd255, 1'b1, 1537, 5};

        // Power-on reset: outputs settle with no clock edge
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            offer(vecs[i].data, vecs[i].d, vecs[i].fill);
            check_word(vecs[i].data, int'(vecs[i].d), vecs[i].fill, 0, 1'b0, '0,
                       vecs[i].exp_done_k, vecs[i].exp_shifts);
        end

        // in_valid held across two words: second accept on the first idle cycle, no duplicate
        a0 = acc_cnt;
        in_valid = 1'b1;
        in_data  = 6'b100110;
        div      = '0;
        fill_bit = 1'b0;
        @(posedge clk);
        #1;
        in_data  = 6'b011011;
        fill_bit = 1'b1;
        check_word(6'b100110, 0, 1'b0, 0, 1'b0, '0, 7, 5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_word(6'b011011, 0, 1'b1, 0, 1'b0, '0, 7, 5);
        chk("held_valid_accepts", 32'(acc_cnt - a0), 32'd2);

        // Reset during cycle 4 of a div=3 word
        offer(6'b101101, 8'd3, 1'b1);
        check_word(6'b101101, 3, 1'b1, 3, 1'b0, '0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        d0 = done_cnt;
        #1 check_reset_outputs("reset_midword");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt), 32'(d0));
        chk("ready_after_abort", 32'(in_ready), 32'd1);
        offer(6'b110101, 8'd1, 1'b0);
        check_word(6'b110101, 1, 1'b0, 0, 1'b0, '0, 13, 5);

        // div changed mid-word only takes effect on the following word
        offer(6'b101101, 8'd0, 1'b0);
        check_word(6'b101101, 0, 1'b0, 0, 1'b1, 8'd7, 7, 5);
        offer(6'b010011, div, 1'b1);
        check_word(6'b010011, 7, 1'b1, 0, 1'b0, '0, 49, 5);

        for (int n = 0; n < 12; n++) begin
            rd   = L'($urandom);
            rdiv = DW'($urandom_range(0, 4));
            rf   = 1'($urandom_range(0, 1));
            rchg = 1'($urandom_range(0, 1));
            offer(rd, rdiv, rf);
            check_word(rd, int'(rdiv), rf, 0, rchg, DW'($urandom_range(0, 9)),
                       1 + L * (int'(rdiv) + 1), L - 1);
        end

        chk("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
